// File: rtl/addsub_cla_seq_if.sv
// Handshake bundle between the operand source and the sequential add/sub unit.
// master: operand producer / result consumer. slave: addsub_cla_seq.
interface addsub_cla_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             m;
  logic             ci;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             neg;

  modport master (
    output in_valid, m, ci, a, b, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero, neg
  );

  modport slave (
    input  in_valid, m, ci, a, b, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero, neg
  );
endinterface

// File: rtl/addsub_cla_seq.sv
// Sequential two's-complement adder/subtractor. One SLICE-bit carry-lookahead
// group is added per clock; the group carry ripples through carry_q, so an
// operation takes NSLICE = WIDTH/SLICE cycles in RUN.
// WIDTH must be >= 2 and a multiple of SLICE; SLICE must be >= 1.
// Optional build macro: ADDSUB_SATURATE_EN clamps the result to the signed
// limit on overflow (cout unchanged, zero/neg follow the clamped value).
module addsub_cla_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input logic            clk,
  input logic            rst_n,
  addsub_cla_seq_if.slave bus
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;       // latched operand A
  logic [WIDTH-1:0] b_q;       // latched conditioned operand B (~b when subtracting)
  logic [WIDTH-1:0] acc_q;     // slices of the result under construction
  logic [WIDTH-1:0] sum_q;     // last completed result, held between operations
  logic             carry_q;   // carry into the current slice
  logic [CW-1:0]    cnt_q;     // slice index being processed
  logic             in_ready_q;
  logic             out_valid_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic             neg_q;

  logic [SLICE:0]   c;         // c[0] = slice carry-in, c[SLICE] = slice carry-out
  logic [SLICE-1:0] s;         // slice sum bits
  logic [WIDTH-1:0] acc_next;  // acc_q with the current slice merged in
  logic [WIDTH-1:0] res;       // final result as it will be presented
  logic             ovf_next;

  // Carry-lookahead for the current slice: each carry is expanded into its
  // full generate/propagate sum-of-products rather than rippled bit by bit.
  // NOTE: every variable written here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin : cla
    logic [SLICE-1:0] a_s, b_s, p, g;
    logic             term, prop;
    int               base;
    base = int'(cnt_q) * SLICE;
    a_s  = a_q[base +: SLICE];
    b_s  = b_q[base +: SLICE];
    p    = a_s ^ b_s;
    g    = a_s & b_s;
    c    = '0;
    term = 1'b0;
    prop = 1'b0;
    c[0] = carry_q;
    for (int i = 0; i < SLICE; i++) begin
      term = g[i];
      prop = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        term = term | (prop & g[j]);
        prop = prop & p[j];
      end
      c[i+1] = term | (prop & carry_q);
    end
    s        = p ^ c[SLICE-1:0];
    acc_next = acc_q;
    acc_next[base +: SLICE] = s;
  end

  // Overflow uses the carry into and out of the MSB; for SLICE=1 the carry
  // into the MSB is carry_q itself (c[0]).
  always_comb begin
    ovf_next = c[SLICE] ^ c[SLICE-1];
    res      = acc_next;
`ifdef ADDSUB_SATURATE_EN
    if (ovf_next) begin
      res = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // Control FSM with registered handshake outputs and result/flag registers.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.a;
            b_q        <= bus.m ? ~bus.b : bus.b;
            carry_q    <= bus.ci ^ bus.m;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          acc_q   <= acc_next;
          carry_q <= c[SLICE];
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            sum_q       <= res;
            cout_q      <= c[SLICE];
            ovf_q       <= ovf_next;
            zero_q      <= (res == '0);
            neg_q       <= res[WIDTH-1];
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;

endmodule

// File: tb/tb_addsub_cla_seq.sv
// Self-checking bench for addsub_cla_seq (WIDTH=16, SLICE=4). Expected
// results come from a plain-arithmetic model of a - b - ci / a + b + ci.
module tb_addsub_cla_seq;

  localparam int WIDTH  = 16;
  localparam int SLICE  = 4;
  localparam int NSLICE = WIDTH / SLICE;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             neg;
  } res_t;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             m;
    logic             ci;
    res_t             exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  addsub_cla_seq_if #(.WIDTH(WIDTH)) bus ();

  addsub_cla_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: integer arithmetic on the operands, signed range test for ovf.
  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic m, input logic ci);
    res_t        r;
    longint      ua, ub, full, sa, sb, sres;
    ua   = longint'(a);
    ub   = longint'(b);
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    if (m) begin
      full = ua + ((1 << WIDTH) - 1 - ub) + (ci ? 0 : 1);
      sres = sa - sb - (ci ? 1 : 0);
    end else begin
      full = ua + ub + (ci ? 1 : 0);
      sres = sa + sb + (ci ? 1 : 0);
    end
    r.sum  = full[WIDTH-1:0];
    r.cout = (full >= (1 << WIDTH));
    r.ovf  = (sres > ((1 << (WIDTH-1)) - 1)) || (sres < -(1 << (WIDTH-1)));
`ifdef ADDSUB_SATURATE_EN
    if (r.ovf) r.sum = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    r.zero = (r.sum == '0);
    r.neg  = r.sum[WIDTH-1];
    return r;
  endfunction

  function automatic res_t observe();
    res_t r;
    r.sum  = bus.sum;
    r.cout = bus.cout;
    r.ovf  = bus.ovf;
    r.zero = bus.zero;
    r.neg  = bus.neg;
    return r;
  endfunction

  // Drives one operation through acceptance and waits (bounded) for out_valid.
  // Leaves the result unconsumed. Inputs wiggle randomly while RUN is active.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic m, input logic ci, input bit early,
                       output res_t obs, output int lat, output bit ok);
    int w;
    w   = 0;
    lat = 0;
    ok  = 1'b0;
    obs = '0;
    while (!bus.in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!bus.in_ready) return;
    bus.a = a; bus.b = b; bus.m = m; bus.ci = ci;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.a         = WIDTH'($urandom);
    bus.b         = WIDTH'($urandom);
    bus.m         = 1'($urandom);
    bus.ci        = 1'($urandom);
    bus.out_ready = early;
    do begin
      @(posedge clk); #1;
      lat++;
      if (!bus.out_valid) bus.in_valid = 1'($urandom);
    end while (!bus.out_valid && lat < 20);
    bus.in_valid = 1'b0;
    obs = observe();
    ok  = bus.out_valid;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.m = 1'b0; bus.ci = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, observe()} !== {1'b1, 1'b0, res_t'('0)}) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b sum=%h c=%b v=%b z=%b n=%b, want in_ready=1 out_valid=0 all zero",
               bus.in_ready, bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero, bus.neg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    vec_t vecs[4];
    res_t obs, exp_ovf;
    int   lat;
    bit   ok;
    exp_ovf.sum = 16'h8000; exp_ovf.cout = 0; exp_ovf.ovf = 1; exp_ovf.zero = 0; exp_ovf.neg = 1;
`ifdef ADDSUB_SATURATE_EN
    exp_ovf.sum = 16'h7FFF; exp_ovf.neg = 0;
`endif
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, res_t'({16'h5555, 1'b0, 1'b0, 1'b0, 1'b0})};
    vecs[1] = '{16'h00FF, 16'h00FF, 1'b1, 1'b0, res_t'({16'h0000, 1'b1, 1'b0, 1'b1, 1'b0})};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, exp_ovf};
    vecs[3] = '{16'hFFFF, 16'h0000, 1'b0, 1'b1, res_t'({16'h0000, 1'b1, 1'b0, 1'b1, 1'b0})};
    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].ci, 1'b0, obs, lat, ok);
      checks++;
      if (!ok || lat != NSLICE) begin
        errors++;
        $display("FAIL directed_latency[%0d]: valid=%b after %0d edges, want valid after %0d", i, ok, lat, NSLICE);
      end
      checks++;
      if (obs !== vecs[i].exp) begin
        errors++;
        $display("FAIL directed_result[%0d]: got sum=%h c=%b v=%b z=%b n=%b, want sum=%h c=%b v=%b z=%b n=%b",
                 i, obs.sum, obs.cout, obs.ovf, obs.zero, obs.neg, vecs[i].exp.sum,
                 vecs[i].exp.cout, vecs[i].exp.ovf, vecs[i].exp.zero, vecs[i].exp.neg);
      end
      consume();
      checks++;
      if ({bus.in_ready, bus.out_valid, observe()} !== {1'b1, 1'b0, vecs[i].exp}) begin
        errors++;
        $display("FAIL directed_hold[%0d]: in_ready=%b out_valid=%b sum=%h, want in_ready=1 out_valid=0 sum=%h held",
                 i, bus.in_ready, bus.out_valid, bus.sum, vecs[i].exp.sum);
      end
    end
  endtask

  task automatic test_random();
    res_t obs, exp;
    int   lat;
    bit   ok;
    logic [WIDTH-1:0] a, b;
    logic m, ci;
    logic [WIDTH-1:0] corners[4];
    corners[0] = 16'h7FFF; corners[1] = 16'h8000; corners[2] = 16'hFFFF; corners[3] = 16'h0000;
    for (int n = 0; n < 150; n++) begin
      a  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : WIDTH'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : WIDTH'($urandom);
      m  = 1'($urandom);
      ci = 1'($urandom);
      exp = model(a, b, m, ci);
      do_op(a, b, m, ci, 1'($urandom), obs, lat, ok);
      checks++;
      if (!ok || lat != NSLICE || obs !== exp) begin
        errors++;
        $display("FAIL random[%0d] a=%h b=%h m=%b ci=%b: valid=%b lat=%0d sum=%h c=%b v=%b z=%b n=%b, want lat=%0d sum=%h c=%b v=%b z=%b n=%b",
                 n, a, b, m, ci, ok, lat, obs.sum, obs.cout, obs.ovf, obs.zero, obs.neg,
                 NSLICE, exp.sum, exp.cout, exp.ovf, exp.zero, exp.neg);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    res_t obs, exp, exp2;
    int   lat;
    bit   ok;
    logic [WIDTH-1:0] na, nb;
    exp = model(16'h1111, 16'h2222, 1'b0, 1'b0);
    do_op(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, obs, lat, ok);
    checks++;
    if (!ok || obs !== exp) begin
      errors++;
      $display("FAIL bp_first: valid=%b sum=%h, want valid=1 sum=%h", ok, obs.sum, exp.sum);
    end
    for (int k = 0; k < 10; k++) begin
      bus.in_valid = 1'b1;
      bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom);
      @(posedge clk); #1;
      checks++;
      if ({bus.in_ready, bus.out_valid, observe()} !== {1'b0, 1'b1, exp}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: in_ready=%b out_valid=%b sum=%h, want in_ready=0 out_valid=1 sum=%h",
                 k, bus.in_ready, bus.out_valid, bus.sum, exp.sum);
      end
    end
    na = WIDTH'($urandom); nb = WIDTH'($urandom);
    exp2 = model(na, nb, 1'b1, 1'b1);
    bus.a = na; bus.b = nb; bus.m = 1'b1; bus.ci = 1'b1;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b, want in_ready=1 out_valid=0", bus.in_ready, bus.out_valid);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept: in_ready=%b, want 0 after accepting edge", bus.in_ready);
    end
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.out_valid && lat < 20);
    obs = observe();
    checks++;
    if (!bus.out_valid || lat != NSLICE || obs !== exp2) begin
      errors++;
      $display("FAIL bp_second: valid=%b lat=%0d sum=%h c=%b, want lat=%0d sum=%h c=%b",
               bus.out_valid, lat, obs.sum, obs.cout, NSLICE, exp2.sum, exp2.cout);
    end
    consume();
  endtask

  task automatic test_reset_mid_op();
    res_t obs, exp;
    int   lat;
    bit   ok;
    bit   seen;
    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, obs, lat, ok);
    consume();
    bus.a = 16'h0F0F; bus.b = 16'h3333; bus.m = 1'b0; bus.ci = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, observe()} !== {1'b1, 1'b0, res_t'('0)}) begin
      errors++;
      $display("FAIL midop_reset: in_ready=%b out_valid=%b sum=%h, want in_ready=1 out_valid=0 sum=0000",
               bus.in_ready, bus.out_valid, bus.sum);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL midop_abort: out_valid seen=1 after aborted op, want 0");
    end
    exp = model(16'h0002, 16'h0003, 1'b1, 1'b0);
    do_op(16'h0002, 16'h0003, 1'b1, 1'b0, 1'b0, obs, lat, ok);
    checks++;
    if (!ok || lat != NSLICE || obs !== exp ||
        {obs.sum, obs.neg, obs.cout} !== {16'hFFFF, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL midop_after: valid=%b lat=%0d sum=%h n=%b c=%b, want sum=ffff n=1 c=0 (model sum=%h)",
               ok, lat, obs.sum, obs.neg, obs.cout, exp.sum);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
